// File: rtl/mac3_pkg.sv
// Shared defaults and data types for the mac3_stream block.
// The RTL modules take their own parameters. These types match the default widths.
package mac3_pkg;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  typedef logic [W-1:0]             data_t;
  typedef logic [2*W-1:0]           prod_t;
  typedef logic [$clog2(DEPTH):0]   ptr_t;

endpackage

// File: rtl/mac3_fifo.sv
// Synchronous result FIFO. Each pointer carries one extra wrap bit,
// which lets the FIFO tell full from empty.
module mac3_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] fptr_t;

  logic [W-1:0] mem_q [DEPTH];
  fptr_t        wr_ptr_q, wr_ptr_d;
  fptr_t        rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + fptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + fptr_t'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mac3_stream.sv
// Sliding three-sample multiply-accumulate (s2*s1 + data_in) over runs of valid input.
// Results are queued in an output FIFO, and any result dropped on overflow is counted.
module mac3_stream #(
  parameter int W     = mac3_pkg::W,
  parameter int DEPTH = mac3_pkg::DEPTH,
  parameter int CW    = mac3_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          validi,
  input  logic [W-1:0]  data_in,
  input  logic          ready_i,
  output logic          valido,
  output logic [W-1:0]  data_out,
  output logic          overflow,
  output logic [CW-1:0] drop_cnt
);

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] wide_t;

  logic [1:0]    run_q, run_d;
  word_t         s1_q, s1_d, s2_q, s2_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          fire, pop, drop;
  word_t         res;
  logic          fifo_empty, fifo_full;

  assign pop = !fifo_empty && ready_i;

  // NOTE: every always_comb output gets a default first, so no latches are inferred.
  always_comb begin
    run_d      = 2'd0;
    s1_d       = s1_q;
    s2_d       = s2_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    fire       = validi && (run_q == 2'd2);
    // The full-width product is truncated only after the add.
    res        = word_t'(wide_t'(s2_q) * wide_t'(s1_q) + wide_t'(data_in));
    drop       = fire && fifo_full && !pop;
    if (validi) begin
      run_d = (run_q == 2'd2) ? 2'd2 : run_q + 2'd1;
      s2_d  = s1_q;
      s1_d  = data_in;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      run_q      <= 2'd0;
      s1_q       <= '0;
      s2_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      run_q      <= run_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  mac3_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .push      (fire),
    .push_data (res),
    .pop       (pop),
    .head      (data_out),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign valido   = !fifo_empty;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mac3_stream.sv
// Self-checking bench for mac3_stream: a lockstep reference model feeds a scoreboard queue,
// and table vectors and hand-written corner sequences check against constants.
module tb_mac3_stream;
  import mac3_pkg::*;

  localparam int TB_DEPTH = 4;
  localparam int TB_CW    = 8;

  logic             clk = 1'b0;
  logic             rst_;
  logic             validi;
  data_t            data_in;
  logic             ready_i;
  logic             valido;
  data_t            data_out;
  logic             overflow;
  logic [TB_CW-1:0] drop_cnt;

  mac3_stream #(.W(32), .DEPTH(TB_DEPTH), .CW(TB_CW)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .validi   (validi),
    .data_in  (data_in),
    .ready_i  (ready_i),
    .valido   (valido),
    .data_out (data_out),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  data_t      sb[$];
  int         m_run;
  data_t      m_s1, m_s2;
  logic       m_ovf;
  int         m_drop;

  typedef struct {
    data_t a;
    data_t b;
    data_t c;
    data_t exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic  exp_v;
    data_t exp_d;
    exp_v = (sb.size() > 0);
    exp_d = exp_v ? sb[0] : 32'h0;
    check("valido",   {31'b0, valido},   {31'b0, exp_v});
    check("data_out", data_out,          exp_d);
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    check("drop_cnt", {24'b0, drop_cnt}, 32'(m_drop));
  endtask

  task automatic model_clear();
    sb.delete();
    m_run  = 0;
    m_s1   = '0;
    m_s2   = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic step(input logic v, input data_t d, input logic r);
    logic        pop_m, fire_m;
    logic [63:0] wide;
    check_outputs();
    validi  = v;
    data_in = d;
    ready_i = r;
    pop_m   = (sb.size() > 0) && r;
    fire_m  = v && (m_run == 2);
    wide    = {32'b0, m_s2} * {32'b0, m_s1} + {32'b0, d};
    if (pop_m) void'(sb.pop_front());
    if (fire_m) begin
      if (sb.size() == TB_DEPTH) begin
        m_ovf = 1'b1;
        if (m_drop != 255) m_drop++;
      end else begin
        sb.push_back(wide[31:0]);
      end
    end
    if (v) begin
      m_run = (m_run == 2) ? 2 : m_run + 1;
      m_s2  = m_s1;
      m_s1  = d;
    end else begin
      m_run = 0;
    end
    @(negedge clk);
  endtask

  task automatic reset_cycles(input int n);
    rst_    = 1'b0;
    validi  = 1'b1;
    data_in = 32'h55;
    ready_i = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst_valido",   {31'b0, valido},   32'h0);
      check("rst_data_out", data_out,          32'h0);
      check("rst_overflow", {31'b0, overflow}, 32'h0);
      check("rst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
    end
    model_clear();
    rst_   = 1'b1;
    validi = 1'b0;
  endtask

  vec_t  tbl[6];
  data_t drain[4];
  int    gap_pat[7];

  initial begin
    tbl[0] = '{32'd2,        32'd3,        32'd4,  32'd10};
    tbl[1] = '{32'hFFFFFFFF, 32'd2,        32'd3,  32'h00000001};
    tbl[2] = '{32'd0,        32'd0,        32'd0,  32'd0};
    tbl[3] = '{32'h0000FFFF, 32'h00010000, 32'd5,  32'hFFFF0005};
    tbl[4] = '{32'h80000000, 32'd2,        32'd7,  32'd7};
    tbl[5] = '{32'd1000,     32'd1000,     32'd1,  32'h000F4241};
    drain   = '{32'd5, 32'd10, 32'd17, 32'd26};
    gap_pat = '{1, 1, 0, 1, 1, 0, 1};

    rst_ = 1'b0; validi = 1'b0; data_in = '0; ready_i = 1'b0;
    model_clear();
    reset_cycles(2);

    // Sliding window 2,3,4,5
    step(1, 32'd2, 1);
    step(1, 32'd3, 1);
    step(1, 32'd4, 1);
    check("slide_first", data_out, 32'd10);
    step(1, 32'd5, 1);
    check("slide_second", data_out, 32'd17);
    step(0, 32'd0, 1);
    check("slide_done", {31'b0, valido}, 32'h0);
    step(0, 32'd0, 1);

    // Broken runs never fire
    foreach (gap_pat[i]) begin
      step(gap_pat[i][0], 32'd7, 1);
      check("gap_no_fire", {31'b0, valido}, 32'h0);
    end
    step(0, 32'd0, 1);

    // Table vectors: three valids, then a gap
    for (int i = 0; i < 6; i++) begin
      step(1, tbl[i].a, 1);
      step(1, tbl[i].b, 1);
      step(1, tbl[i].c, 1);
      check("tbl_valido", {31'b0, valido}, 32'h1);
      check("tbl_result", data_out, tbl[i].exp);
      step(0, 32'd0, 1);
      step(0, 32'd0, 1);
    end

    // Overflow: 7 valids with ready low give 5 results, 4 kept and 1 dropped
    for (int i = 1; i <= 7; i++) step(1, data_t'(i), 0);
    check("ovf_flag", {31'b0, overflow}, 32'h1);
    check("ovf_cnt",  {24'b0, drop_cnt}, 32'h1);
    step(0, 32'd0, 0);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", data_out, drain[i]);
      step(0, 32'd0, 1);
    end
    check("drain_empty", {31'b0, valido}, 32'h0);
    step(0, 32'd0, 1);

    // Simultaneous push and pop while full: both honoured, no drop
    for (int i = 1; i <= 6; i++) step(1, data_t'(i), 0);
    step(1, 32'd7, 1);
    check("full_pushpop_cnt", {24'b0, drop_cnt}, 32'h1);
    for (int i = 0; i < 5; i++) step(0, 32'd0, 1);

    // Reset mid-run discards queued results and history
    for (int i = 10; i <= 14; i++) step(1, data_t'(i), 0);
    check("pre_rst_valido", {31'b0, valido}, 32'h1);
    reset_cycles(1);
    step(1, 32'd2, 1);
    check("post_rst_1", {31'b0, valido}, 32'h0);
    step(1, 32'd3, 1);
    check("post_rst_2", {31'b0, valido}, 32'h0);
    step(1, 32'd4, 1);
    check("post_rst_fire", data_out, 32'd10);
    step(0, 32'd0, 1);
    step(0, 32'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac3_stream.md
Name: mac3_stream

Overview:
- Streaming design block that drives the protocol the ex1_1 property checker observes.
- Tracks consecutive valid input samples and, on every third-or-later consecutive valid sample, emits data_out = a*b+c.
  - a = data_in two cycles back; b = data_in one cycle back; c = current data_in.
- Results enter a small output FIFO drained by a downstream ready signal.
- Drops on FIFO overflow are counted and flagged.

Parameters:
- W, 32, data width of data_in and data_out.
- DEPTH, 4, output FIFO entries (power of two, >= 2).
- CW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_  in  1  synchronous active-low reset; sampled on rising clk edge.
- validi  in  1  data_in is valid this cycle.
- data_in  in  W  input sample.
- ready_i  in  1  downstream accepts the current data_out when valido=1.
- valido  out  1  data_out holds a valid result (FIFO not empty).
- data_out  out  W  FIFO head result; 0 when FIFO empty.
- overflow  out  1  sticky: a result was dropped since reset.
- drop_cnt  out  CW  number of dropped results, saturates at 2^CW-1.

Behaviour:
- Reset (rst_=0 at a clk edge), applied regardless of other inputs:
  - valido=0, data_out=0, overflow=0, drop_cnt=0.
  - FIFO empty, run counter 0, sample history cleared.
- Run counter run (0..2, saturating):
  - validi=1: run <= min(run+1, 2).
  - validi=0: run <= 0.
- Sample history: s1 = previous sample, s2 = sample before that. Shifts only when validi=1.
- Fire condition: validi=1 AND run==2, i.e. validi has been high this cycle and the two preceding cycles.
- Result when fired: res = (s2*s1 + data_in) mod 2^W.
  - Full 2W product computed internally, then truncated.
  - Unsigned arithmetic.
- Latency: a result fired in cycle t is pushed at the edge ending cycle t.
  - If the FIFO was empty, valido=1 and data_out=res in cycle t+1. This matches "validi ##1 validi ##1 validi |=> valido".
- Continuous validi: one result per cycle after the first two samples (a sliding window).
- validi=0 in any cycle: no result that cycle, and three fresh consecutive valids are needed before the next result.
- FIFO:
  - Pop when valido && ready_i.
  - Push when fire.
  - Push and pop in the same cycle are both honoured, including when full; count unchanged, no drop.
  - Push with FIFO full and no pop: result discarded, overflow <= 1, drop_cnt <= drop_cnt+1 (saturating).
  - Pop when empty: no effect.
  - Read and write pointers wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.
- Outputs are registered or driven from FIFO state only; there is no combinational path from validi/data_in to valido/data_out.
- Reset mid-run discards all queued results and history; no result is produced until three consecutive valids are seen after reset is released.

Decomposition:
- Package mac3_pkg holds:
  - Default localparams W/DEPTH/CW.
  - typedef data_t (logic [W-1:0]).
  - typedef prod_t (logic [2W-1:0]).
  - typedef ptr_t (logic [$clog2(DEPTH):0]).
- Sub-module mac3_fifo:
  - Synchronous FIFO, parameterised by W/DEPTH, same clk/rst_.
  - Ports: push/push_data, pop, head, empty, full.
- Top holds the run counter, history, arithmetic, and drop/overflow logic.

Test Plan:
- Assert rst_=0 for 2 cycles, then release -> valido=0, data_out=0, overflow=0, drop_cnt=0 throughout reset.
- ready_i=1; validi=1 with data_in 2,3,4,5 on consecutive cycles -> valido=1 with data_out=10 one cycle after 4, then data_out=17 one cycle after 5; valido=0 afterwards.
- ready_i=1; validi pattern 1,1,0,1,1,0,1 (data 7 each) -> valido never asserted.
- ready_i=1; data_in 0xFFFFFFFF, 2, 3 consecutively valid -> data_out=0x00000001 (truncation of 0x200000001).
- DEPTH=4, ready_i=0; 7 consecutive valid samples (5 results) -> 4 queued, overflow=1, drop_cnt=1. Then ready_i=1 -> 4 results drain in order, one per cycle, then valido=0.
- 3 samples queued, assert rst_=0 for 1 cycle, then two valids -> valido=0 immediately after reset and stays 0. A third consecutive valid produces a result one cycle later.
